sample_recover: RTL and testbench
=================================

SAMPLE_RECOVER -- requirements
Module: sample_recover

Interface
REQ-001 Parameter WINDOW_SIZE, default 100: averaging window N of the upstream averager being inverted; legal range 2..127.
REQ-002 Parameter DATA_WIDTH, default 24: sample/average width, signed Q7.16.
REQ-003 Parameter FRACTIONAL_BITS, default 16: fractional bits of in_avg and out_sample.
REQ-004 Parameter SUM_WIDTH, default 32: width of internal window sums and buffer entries, signed.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clk_en  input  1  global enable; state advances only when high.
REQ-008 clear  input  1  synchronous restart, qualified by clk_en.
REQ-009 valid_in  input  1  in_avg is valid this clk_en cycle.
REQ-010 in_avg  input  DATA_WIDTH  signed running average y[n] of the last min(n+1,N) samples.
REQ-011 valid_out  output  1  out_sample is valid; downstream qualifies with clk_en.
REQ-012 out_sample  output  DATA_WIDTH  signed recovered sample x[n].

Function
REQ-013 The block SHALL invert a running average: x[n] = S[n] - S[n-1] + (full ? x[n-N] : 0), where S[n] = y[n] * k[n].
REQ-014 k SHALL be the post-increment accepted-sample count, saturating at N, so k = 1,2,...,N,N,...
REQ-015 Stage 1, on clk_en & valid_in: P <= sign-extended in_avg * k (integer multiply, SUM_WIDTH result, no shift); count update; full flag captured as (count before increment == N).
REQ-016 Stage 2, on the next clk_en cycle with stage-1 valid: x = P - S_prev + (full ? buf[idx] : 0), computed in SUM_WIDTH+2 bits; S_prev <= P; buf[idx] <= x truncated to SUM_WIDTH; idx <= idx+1, wrapping N-1 -> 0.
REQ-017 out_sample SHALL be x saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; buf holds the unsaturated value.
REQ-018 Latency SHALL be 2 clk_en-high cycles from valid_in to valid_out; throughput one sample per clk_en cycle, back-to-back supported.
REQ-019 valid_out SHALL be registered, high for exactly one clk_en-high cycle per accepted input; out_sample holds its last value when valid_out is low.
REQ-020 With clk_en low, all registers including valid_out and out_sample SHALL hold.
REQ-021 clear (with clk_en) SHALL zero count, idx, S_prev, the stage-1 valid flag, and valid_out; it drops any in-flight sample; buf need not be cleared; valid_in in the same cycle is ignored.
REQ-022 Buffer reads of buf[idx] for full=1 SHALL return the value written N accepted samples earlier, including when the write happens in the preceding cycle.

Reset
REQ-023 reset_n low SHALL immediately clear count, idx, S_prev, pipeline valids, valid_out=0, out_sample=0, and all buf entries; no output until a new valid_in is accepted after release.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight samples; the first output after release equals the first post-reset in_avg.

Verification
REQ-025 Reset: assert reset_n=0 mid-stream -> valid_out=0, out_sample=0x000000 immediately; after release, first in_avg 0x020000 -> out 0x020000.
REQ-026 N=4, constant in_avg 0x010000 x6, clk_en=1 -> six valid_out pulses, each out 0x010000, first 2 cycles after first valid_in.
REQ-027 N=4, in_avg 1.0,1.5,2.0,2.5,3.5 (0x010000,0x018000,0x020000,0x028000,0x038000) -> out 0x010000,0x020000,0x030000,0x040000,0x050000 (wrap/full path).
REQ-028 N=4, in_avg 0x800000 then 0x7FFFFF -> out 0x800000 then saturated 0x7FFFFF.
REQ-029 Stall: clk_en toggled 1,0,0,1 during back-to-back valid_in -> outputs identical to the unstalled run, valid_out and out_sample held during clk_en=0.
REQ-030 clear pulsed after 5 samples (N=4) with valid_in high -> in-flight dropped, no valid_out next cycle, then in_avg 0x030000 -> out 0x030000.

Source files
------------

// File: rtl/sample_recover.sv
// sample_recover: inverts an upstream running-average filter, recovering the
// original sample stream x[n] from the averages y[n].
//
//   x[n] = S[n] - S[n-1] + (full ? x[n-N] : 0),  S[n] = y[n] * k[n]
//   k[n] = min(n+1, N)
//
// Two-stage pipeline: stage 1 forms S = y*k, stage 2 forms x and updates the
// history of recovered samples. Latency is two clk_en-high cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clk_en     global enable; all state holds while low
//   clear      synchronous restart, qualified by clk_en
//   valid_in   in_avg valid this clk_en cycle
//   in_avg     signed running average, Q(DATA_WIDTH-FRACTIONAL_BITS).FRACTIONAL_BITS
//   valid_out  one clk_en-cycle pulse per accepted input
//   out_sample recovered sample, saturated to DATA_WIDTH; held when valid_out low
module sample_recover #(
  parameter int WINDOW_SIZE     = 100,
  parameter int DATA_WIDTH      = 24,
  parameter int FRACTIONAL_BITS = 16,
  parameter int SUM_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  clear,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] in_avg,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] out_sample
);

  localparam int CNT_W    = $clog2(WINDOW_SIZE + 1);
  localparam int IDX_W    = $clog2(WINDOW_SIZE);
  localparam int X_W      = SUM_WIDTH + 2;
  localparam int INT_BITS = DATA_WIDTH - FRACTIONAL_BITS;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(WINDOW_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_SIZE - 1);

  // Clamp a wide signed value into the DATA_WIDTH output range.
  function automatic logic [DATA_WIDTH-1:0] saturate(input logic [X_W-1:0] v);
    logic [DATA_WIDTH-1:0] max_pos;
    logic [DATA_WIDTH-1:0] min_neg;
    max_pos = {1'b0, {(INT_BITS-1){1'b1}}, {FRACTIONAL_BITS{1'b1}}};
    min_neg = ~max_pos;
    // In range when every bit above the output sign bit matches it.
    if ((&v[X_W-1:DATA_WIDTH-1]) || !(|v[X_W-1:DATA_WIDTH-1])) begin
      saturate = v[DATA_WIDTH-1:0];
    end else if (v[X_W-1]) begin
      saturate = min_neg;
    end else begin
      saturate = max_pos;
    end
  endfunction

  // Pipeline / history state
  logic [CNT_W-1:0]     count_r;
  logic [IDX_W-1:0]     idx_r;
  logic [SUM_WIDTH-1:0] s_prev_r;
  logic [SUM_WIDTH-1:0] p_r;
  logic                 full_r;
  logic                 s1_valid_r;
  logic [SUM_WIDTH-1:0] hist_r [0:WINDOW_SIZE-1];

  logic [CNT_W-1:0]            count_next_s;
  logic signed [SUM_WIDTH-1:0] avg_ext_s;
  logic signed [SUM_WIDTH-1:0] k_ext_s;
  logic signed [SUM_WIDTH-1:0] product_s;
  logic [SUM_WIDTH-1:0]        hist_rd_s;
  logic [X_W-1:0]              hist_term_s;
  logic [X_W-1:0]              x_s;
  logic [IDX_W-1:0]            idx_next_s;

  // Post-increment sample count, saturating at N (this is the multiplier k).
  always_comb begin
    count_next_s = count_r;
    if (count_r == N_CNT) begin
      count_next_s = N_CNT;
    end else begin
      count_next_s = count_r + CNT_W'(1);
    end
  end

  assign avg_ext_s = {{(SUM_WIDTH-DATA_WIDTH){in_avg[DATA_WIDTH-1]}}, in_avg};
  assign k_ext_s   = {{(SUM_WIDTH-CNT_W){1'b0}}, count_next_s};
  assign product_s = avg_ext_s * k_ext_s;

  // The entry at idx was written exactly N recovered samples ago, so once the
  // window is full it holds x[n-N].
  assign hist_rd_s   = hist_r[idx_r];
  assign hist_term_s = full_r ? {{2{hist_rd_s[SUM_WIDTH-1]}}, hist_rd_s} : {X_W{1'b0}};
  assign x_s = {{2{p_r[SUM_WIDTH-1]}}, p_r}
             - {{2{s_prev_r[SUM_WIDTH-1]}}, s_prev_r}
             + hist_term_s;
  assign idx_next_s = (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);

  // Two-stage datapath, history buffer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r    <= {CNT_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      s_prev_r   <= {SUM_WIDTH{1'b0}};
      p_r        <= {SUM_WIDTH{1'b0}};
      full_r     <= 1'b0;
      s1_valid_r <= 1'b0;
      valid_out  <= 1'b0;
      out_sample <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        hist_r[i] <= {SUM_WIDTH{1'b0}};
      end
    end else if (clk_en) begin
      if (clear) begin
        // History entries are left stale; full stays low until N new samples.
        count_r    <= {CNT_W{1'b0}};
        idx_r      <= {IDX_W{1'b0}};
        s_prev_r   <= {SUM_WIDTH{1'b0}};
        s1_valid_r <= 1'b0;
        valid_out  <= 1'b0;
      end else begin
        s1_valid_r <= valid_in;
        if (valid_in) begin
          p_r     <= product_s;
          count_r <= count_next_s;
          full_r  <= (count_r == N_CNT);
        end
        valid_out <= s1_valid_r;
        if (s1_valid_r) begin
          s_prev_r      <= p_r;
          hist_r[idx_r] <= x_s[SUM_WIDTH-1:0];
          idx_r         <= idx_next_s;
          out_sample    <= saturate(x_s);
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_recover.sv
// Self-checking bench for sample_recover (N=4). A reference model recomputes
// each recovered sample from the running-average inversion formula on a
// history of past outputs, and a one-slot delay represents the pipeline.
module tb_sample_recover;

  localparam int N  = 4;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          clk_en = 1'b0;
  logic          clear = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] in_avg = '0;
  logic          valid_out;
  logic [DW-1:0] out_sample;

  int errors = 0;
  int checks = 0;

  // Reference model state
  longint        hist[$];
  longint        s_prev = 0;
  logic          pv = 1'b0;
  logic [DW-1:0] pd = '0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_out = '0;

  sample_recover #(
    .WINDOW_SIZE(N), .DATA_WIDTH(DW), .FRACTIONAL_BITS(16), .SUM_WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .clear(clear),
    .valid_in(valid_in), .in_avg(in_avg),
    .valid_out(valid_out), .out_sample(out_sample)
  );

  always #5 clk = ~clk;

  function automatic longint trunc32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  function automatic logic [DW-1:0] sat24(input longint v);
    longint r;
    if (v > 64'sd8388607) r = 64'sd8388607;
    else if (v < -64'sd8388608) r = -64'sd8388608;
    else r = v;
    return r[DW-1:0];
  endfunction

  // Accept one average: S = y*min(n+1,N); x = S - S_prev + x[n-N] once full.
  function automatic logic [DW-1:0] model_accept(input logic [DW-1:0] y_in);
    longint y, k, s, x;
    int n;
    n = hist.size();
    y = longint'($signed(y_in));
    k = (n + 1 < N) ? longint'(n + 1) : longint'(N);
    s = trunc32(y * k);
    x = s - s_prev + ((n >= N) ? hist[n-N] : 64'sd0);
    hist.push_back(trunc32(x));
    s_prev = s;
    return sat24(x);
  endfunction

  task automatic model_clear();
    hist.delete();
    s_prev = 0;
    pv = 1'b0;
  endtask

  // Drive one cycle, advance the model on the rising edge, settle 1 time unit.
  task automatic step(input logic en, input logic vin, input logic [DW-1:0] din,
                      input logic clr);
    clk_en = en; valid_in = vin; in_avg = din; clear = clr;
    @(posedge clk);
    if (en) begin
      if (clr) begin
        exp_valid = 1'b0;
        model_clear();
      end else begin
        exp_valid = pv;
        if (pv) exp_out = pd;
        pv = vin;
        if (vin) pd = model_accept(din);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || out_sample !== 24'h000000) begin
      errors++;
      $display("FAIL reset_init: valid_out=%b out=%h, want 0 000000", valid_out, out_sample);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 24'(($urandom_range(0, 1023)) << 8), 1'b0);
    // Asynchronous assertion between edges.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || out_sample !== 24'h000000) begin
      errors++;
      $display("FAIL reset_async: valid_out=%b out=%h, want 0 000000", valid_out, out_sample);
    end
    model_clear(); exp_valid = 1'b0; exp_out = '0;
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
    step(1'b1, 1'b1, 24'h020000, 1'b0);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat1: valid_out=%b, want 0", valid_out);
    end
    step(1'b1, 1'b0, 24'h0, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || out_sample !== 24'h020000 || out_sample !== exp_out) begin
      errors++;
      $display("FAIL reset_first: valid_out=%b out=%h, want 1 020000", valid_out, out_sample);
    end
  endtask

  task automatic test_constant();
    int pulses = 0;
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 6) ? 1'b1 : 1'b0, 24'h010000, 1'b0);
      checks++;
      if (valid_out !== exp_valid || out_sample !== exp_out) begin
        errors++;
        $display("FAIL const_model[%0d]: valid_out=%b out=%h, want %b %h", i, valid_out, out_sample, exp_valid, exp_out);
      end
      if (valid_out === 1'b1) begin
        pulses++;
        checks++;
        if (out_sample !== 24'h010000 || (pulses == 1 && i != 1)) begin
          errors++;
          $display("FAIL const_value[%0d]: out=%h pulse=%0d, want 010000 first at step 1", i, out_sample, pulses);
        end
      end
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL const_pulses: got %0d, want 6", pulses);
    end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] y[5]    = '{24'h010000, 24'h018000, 24'h020000, 24'h028000, 24'h038000};
    logic [DW-1:0] want[5] = '{24'h010000, 24'h020000, 24'h030000, 24'h040000, 24'h050000};
    int j = 0;
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, (i < 5) ? 1'b1 : 1'b0, (i < 5) ? y[i] : 24'h0, 1'b0);
      checks++;
      if (valid_out !== exp_valid || out_sample !== exp_out) begin
        errors++;
        $display("FAIL ramp_model[%0d]: valid_out=%b out=%h, want %b %h", i, valid_out, out_sample, exp_valid, exp_out);
      end
      if (valid_out === 1'b1 && j < 5) begin
        checks++;
        if (out_sample !== want[j]) begin
          errors++;
          $display("FAIL ramp_value[%0d]: out=%h, want %h", j, out_sample, want[j]);
        end
        j++;
      end
    end
    checks++;
    if (j != 5) begin
      errors++;
      $display("FAIL ramp_count: got %0d outputs, want 5", j);
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] y[2]    = '{24'h800000, 24'h7FFFFF};
    logic [DW-1:0] want[2] = '{24'h800000, 24'h7FFFFF};
    int j = 0;
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i < 2) ? 1'b1 : 1'b0, (i < 2) ? y[i] : 24'h0, 1'b0);
      checks++;
      if (valid_out !== exp_valid || out_sample !== exp_out) begin
        errors++;
        $display("FAIL sat_model[%0d]: valid_out=%b out=%h, want %b %h", i, valid_out, out_sample, exp_valid, exp_out);
      end
      if (valid_out === 1'b1 && j < 2) begin
        checks++;
        if (out_sample !== want[j]) begin
          errors++;
          $display("FAIL sat_value[%0d]: out=%h, want %h", j, out_sample, want[j]);
        end
        j++;
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] y[6];
    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] got_q[$];
    logic          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic          hv;
    logic [DW-1:0] ho;
    int p = 0;
    for (int i = 0; i < 6; i++) y[i] = 24'($urandom_range(0, 24'h07FFFF));
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 6) ? 1'b1 : 1'b0, (i < 6) ? y[i] : 24'h0, 1'b0);
      if (valid_out === 1'b1) ref_q.push_back(out_sample);
    end
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      hv = valid_out; ho = out_sample;
      step(pat[c % 4], (p < 6) ? 1'b1 : 1'b0, (p < 6) ? y[p] : 24'h0, 1'b0);
      if (pat[c % 4] && p < 6) p++;
      checks++;
      if (valid_out !== exp_valid || out_sample !== exp_out) begin
        errors++;
        $display("FAIL stall_model[%0d]: valid_out=%b out=%h, want %b %h", c, valid_out, out_sample, exp_valid, exp_out);
      end
      if (!pat[c % 4]) begin
        checks++;
        if (valid_out !== hv || out_sample !== ho) begin
          errors++;
          $display("FAIL stall_hold[%0d]: valid_out=%b out=%h, want held %b %h", c, valid_out, out_sample, hv, ho);
        end
      end else if (valid_out === 1'b1) begin
        got_q.push_back(out_sample);
      end
    end
    checks++;
    if (got_q.size() != 6 || ref_q.size() != 6 || got_q != ref_q) begin
      errors++;
      $display("FAIL stall_equiv: stalled %0d outputs, unstalled %0d, or values differ", got_q.size(), ref_q.size());
    end
  endtask

  task automatic test_clear();
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 24'h010000 + 24'(i << 12), 1'b0);
    step(1'b1, 1'b1, 24'h055555, 1'b1);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_drop: valid_out=%b, want 0", valid_out);
    end
    step(1'b1, 1'b1, 24'h030000, 1'b0);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_inflight: valid_out=%b, want 0", valid_out);
    end
    step(1'b1, 1'b0, 24'h0, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || out_sample !== 24'h030000 || out_sample !== exp_out) begin
      errors++;
      $display("FAIL clear_first: valid_out=%b out=%h, want 1 030000", valid_out, out_sample);
    end
  endtask

  task automatic test_random();
    logic          en, vin, clr;
    logic [DW-1:0] d;
    step(1'b1, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      vin = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) d = 24'($urandom);
      else d = 24'($signed(20'($urandom)));
      step(en, vin, d, clr);
      checks++;
      if (valid_out !== exp_valid || out_sample !== exp_out) begin
        errors++;
        $display("FAIL random[%0d]: valid_out=%b out=%h, want %b %h", i, valid_out, out_sample, exp_valid, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_saturation();
    test_stall();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
